cpu_fetch_sequencer: RTL and testbench
======================================

// Module: cpu_fetch_sequencer
// PURPOSE
//  Instruction fetch/sequencing front end; drives the instruction decoder.
//  Owns PC, IR and the execute-phase flop (state), and fetches 16-bit words from
//  instruction memory over a req/valid handshake.
//  Consumes the decoder's PS, IR_L and NS and presents IR/State back to it.
//  Also provides exec_en so downstream WR/MemWrite act only in execute cycles.
// PARAMETERS
//  RESET_PC        16'h0000  PC value loaded on reset
//  TIMEOUT_CYCLES  64        fetch watchdog limit in cycles (FETCH_TIMEOUT_EN only)
// PORTS
//  clk         in   1   system clock, rising edge
//  reset_n     in   1   async active-low reset
//  imem_req    out  1   fetch request, held until accepted
//  imem_addr   out  16  fetch address (= pc), stable while imem_req=1
//  imem_rdata  in   16  fetched instruction word
//  imem_valid  in   1   imem_rdata valid; ignored when imem_req=0
//  ps          in   2   PC select from decoder
//  ir_l        in   1   decoder: instruction completes normally
//  ns          in   1   decoder: next execute phase (1 = second phase)
//  branch_off  in   16  signed PC offset (decoder K)
//  jump_addr   in   16  absolute jump target (register-file A bus)
//  ir          out  16  instruction register, to decoder IR
//  state       out  1   execute phase, to decoder State
//  pc          out  16  program counter
//  exec_en     out  1   1 in execute cycles; decoder outputs valid
//  halted      out  1   core stopped
//  fetch_fault out  1   watchdog tripped (FETCH_TIMEOUT_EN only)
// BEHAVIOUR
//  Reset (async assert, sync release): pc=RESET_PC, ir=0, state=0, imem_req=0,
//   exec_en=0, halted=0, fetch_fault=0, FSM=FETCH. imem_req rises in the 1st
//   cycle after release; reset mid-fetch drops imem_req immediately.
//  FSM states FETCH, EXEC, HALT:
//   FETCH: imem_req=1, imem_addr=pc. On imem_valid: ir<=imem_rdata, state<=0,
//    go to EXEC. Same-cycle valid is legal, so the minimum fetch time is 1 cycle.
//   EXEC: exec_en=1, imem_req=0. At the clock edge:
//    ns=1                : state<=1, stay in EXEC; pc, ir unchanged.
//    ns=0, ir_l=1        : state<=0, pc updated per ps, go to FETCH.
//    ns=0, ir_l=0        : go to HALT; pc, ir, state held.
//    ns=1 while state=1  : illegal; treated as ns=0.
//   HALT: exec_en=0, imem_req=0, halted=1. Exit only by reset.
//  PC update happens only on the final execute cycle (ns=0, ir_l=1):
//   ps=00 hold; ps=01 pc+1; ps=10 pc+1+branch_off; ps=11 jump_addr.
//   All arithmetic is 16-bit modulo: 16'hFFFF+1 wraps to 16'h0000 and no
//   carry is kept.
//  Throughput: 1-phase instr = 2 cycles min, 2-phase instr = 3 cycles min.
//  imem_valid while imem_req=0 is ignored.
// CONFIGURATION
//  FETCH_TIMEOUT_EN defined: a counter runs in FETCH and clears on acceptance.
//   If it reaches TIMEOUT_CYCLES with no imem_valid, the block drops imem_req,
//   sets fetch_fault=1 and goes to HALT. fetch_fault is sticky until reset.
//  FETCH_TIMEOUT_EN undefined: no counter; fetch_fault tied 0; FETCH waits
//   indefinitely.
// TESTING
//  T1 reset: hold reset_n=0 -> pc=0000, imem_req=0, exec_en=0. Release ->
//   imem_req=1, imem_addr=0000 next cycle.
//  T2 sequential fetch: same-cycle valid, rdata=16'hA123, ps=01, ns=0, ir_l=1
//   -> ir=A123, one EXEC cycle, pc=0001, next imem_addr=0001.
//  T3 two-phase: ns=1 in 1st EXEC -> state=1 for exactly one cycle with pc
//   held; then ps=11, jump_addr=0040 -> fetch from 0040.
//  T4 branch wrap: pc=FFFE, ps=10, branch_off=0003 -> pc=0002.
//  T5 halt/stall: ir_l=0, ns=0 -> halted=1, imem_req=0 forever.
//   Also: valid delayed 5 cycles -> imem_addr stable for 6 cycles.
//  T6 FETCH_TIMEOUT_EN, TIMEOUT_CYCLES=8, imem_valid=0 -> fetch_fault=1 after
//   8 FETCH cycles, then HALT. Reset clears fetch_fault to 0.

Source files
------------

// File: rtl/cpu_fetch_sequencer.sv
// Instruction fetch/sequencing front end: owns PC, IR and execute phase, fetches over req/valid.
// Optional fetch watchdog enabled by defining FETCH_TIMEOUT_EN.
module cpu_fetch_sequencer #(
    parameter logic [15:0] RESET_PC       = 16'h0000,
    parameter int          TIMEOUT_CYCLES = 64
) (
    input  logic        clk,
    input  logic        reset_n,
    output logic        imem_req,
    output logic [15:0] imem_addr,
    input  logic [15:0] imem_rdata,
    input  logic        imem_valid,
    input  logic [1:0]  ps,
    input  logic        ir_l,
    input  logic        ns,
    input  logic [15:0] branch_off,
    input  logic [15:0] jump_addr,
    output logic [15:0] ir,
    output logic        state,
    output logic [15:0] pc,
    output logic        exec_en,
    output logic        halted,
    output logic        fetch_fault
);

    typedef enum logic [1:0] {FETCH, EXEC, HALT} fsm_t;

    fsm_t        fsm_reg, fsm_next;
    logic [15:0] pc_reg, pc_next;
    logic [15:0] ir_reg, ir_next;
    logic        state_reg, state_next;
    logic        fault_reg, fault_next;
    logic        req_en_reg;
    logic        fetch_active;
    logic        timeout_hit;

    // req_en_reg holds the request off until the first edge after reset release.
    assign fetch_active = (fsm_reg == FETCH) && req_en_reg;

`ifdef FETCH_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] tmo_cnt_reg;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tmo_cnt_reg <= '0;
        end else if (fetch_active && !imem_valid) begin
            tmo_cnt_reg <= tmo_cnt_reg + 1'b1;
        end else begin
            tmo_cnt_reg <= '0;
        end
    end

    assign timeout_hit = fetch_active && !imem_valid && (tmo_cnt_reg == TW'(TIMEOUT_CYCLES - 1));
`else
    // Watchdog absent: the limit only matters when the feature is built in.
    assign timeout_hit = (TIMEOUT_CYCLES < 0);
`endif

    always_comb begin
        fsm_next   = fsm_reg;
        pc_next    = pc_reg;
        ir_next    = ir_reg;
        state_next = state_reg;
        fault_next = fault_reg | timeout_hit;
        imem_req   = 1'b0;
        exec_en    = 1'b0;
        halted     = 1'b0;
        case (fsm_reg)
            FETCH: begin
                imem_req = fetch_active;
                if (fetch_active && imem_valid) begin
                    ir_next    = imem_rdata;
                    state_next = 1'b0;
                    fsm_next   = EXEC;
                end else if (timeout_hit) begin
                    fsm_next = HALT;
                end
            end
            EXEC: begin
                exec_en = 1'b1;
                // A second-phase request while already in phase two is treated as final.
                if (ns && !state_reg) begin
                    state_next = 1'b1;
                end else if (ir_l) begin
                    state_next = 1'b0;
                    fsm_next   = FETCH;
                    case (ps)
                        2'b00:   pc_next = pc_reg;
                        2'b01:   pc_next = pc_reg + 16'd1;
                        2'b10:   pc_next = pc_reg + 16'd1 + branch_off;
                        default: pc_next = jump_addr;
                    endcase
                end else begin
                    fsm_next = HALT;
                end
            end
            HALT: begin
                halted = 1'b1;
            end
            default: begin
                fsm_next = HALT;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            fsm_reg    <= FETCH;
            pc_reg     <= RESET_PC;
            ir_reg     <= 16'h0000;
            state_reg  <= 1'b0;
            fault_reg  <= 1'b0;
            req_en_reg <= 1'b0;
        end else begin
            fsm_reg    <= fsm_next;
            pc_reg     <= pc_next;
            ir_reg     <= ir_next;
            state_reg  <= state_next;
            fault_reg  <= fault_next;
            req_en_reg <= 1'b1;
        end
    end

    assign imem_addr   = pc_reg;
    assign pc          = pc_reg;
    assign ir          = ir_reg;
    assign state       = state_reg;
    assign fetch_fault = fault_reg;

endmodule

// File: tb/tb_cpu_fetch_sequencer.sv
// Scoreboard bench for cpu_fetch_sequencer: random memory latency and decoder controls
// checked against a PC/IR reference model.
module tb_cpu_fetch_sequencer;

    localparam logic [15:0] RESET_PC = 16'h0000;
    localparam int          TMO      = 64;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic [15:0] imem_rdata = 16'h0000;
    logic        imem_valid = 1'b0;
    logic [1:0]  ps = 2'b00;
    logic        ir_l = 1'b0;
    logic        ns = 1'b0;
    logic [15:0] branch_off = 16'h0000;
    logic [15:0] jump_addr = 16'h0000;
    logic [15:0] ir;
    logic        state;
    logic [15:0] pc;
    logic        exec_en;
    logic        halted;
    logic        fetch_fault;

    always #5 clk = ~clk;

    cpu_fetch_sequencer #(.RESET_PC(RESET_PC), .TIMEOUT_CYCLES(TMO)) dut (
        .clk(clk), .reset_n(reset_n),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata), .imem_valid(imem_valid),
        .ps(ps), .ir_l(ir_l), .ns(ns), .branch_off(branch_off), .jump_addr(jump_addr),
        .ir(ir), .state(state), .pc(pc), .exec_en(exec_en), .halted(halted), .fetch_fault(fetch_fault)
    );

    typedef struct packed {
        logic        st;
        logic [15:0] pc;
        logic [15:0] ir;
    } xexp_t;

    logic [15:0] fq[$];
    xexp_t       xq[$];
    int          checks = 0;
    int          passes = 0;
    logic [15:0] model_pc;
    logic [15:0] model_ir;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    task automatic abort(input string nm);
        checks++;
        $display("FAIL %s: bound expired", nm);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    endtask

    // Monitor: pops expectations whenever the DUT accepts a fetch or runs an execute cycle.
    logic [15:0] prev_addr = 16'h0000;
    logic        prev_req = 1'b0;
    xexp_t       e;
    logic [15:0] fa;
    always @(negedge clk) begin
        if (reset_n) begin
            if (imem_req && prev_req) check("addr_stable", {16'h0, imem_addr}, {16'h0, prev_addr});
            if (imem_req && imem_valid) begin
                check("fetch_q_depth", 32'(fq.size()), 32'd1);
                if (fq.size() != 0) begin
                    fa = fq.pop_front();
                    check("fetch_addr", {16'h0, imem_addr}, {16'h0, fa});
                end
            end
            if (exec_en) begin
                check("exec_no_req", {31'h0, imem_req}, 32'd0);
                check("exec_q_depth", 32'(xq.size()), 32'd1);
                if (xq.size() != 0) begin
                    e = xq.pop_front();
                    check("exec_state", {31'h0, state}, {31'h0, e.st});
                    check("exec_pc", {16'h0, pc}, {16'h0, e.pc});
                    check("exec_ir", {16'h0, ir}, {16'h0, e.ir});
                end
            end
        end
        prev_req  <= imem_req && reset_n;
        prev_addr <= imem_addr;
    end

    // Entered and left at #1 after a rising edge.
    task automatic do_fetch();
        int d;
        int guard;
        d = ($urandom_range(0, 7) == 0) ? 5 : int'($urandom_range(0, 3));
        guard = 0;
        forever begin
            if (imem_req && d == 0) break;
            if (imem_req) d--;
            imem_valid = 1'b0;
            @(posedge clk); #1;
            guard++;
            if (guard > 50) abort("fetch_wait");
        end
        imem_valid = 1'b1;
        imem_rdata = 16'($urandom);
        model_ir   = imem_rdata;
        fq.push_back(model_pc);
        @(posedge clk); #1;
    endtask

    task automatic do_exec(input bit halt_now);
        logic        st;
        logic [15:0] bo;
        logic [15:0] ja;
        st = 1'b0;
        if ($urandom_range(0, 1) == 1) begin
            ns = 1'b1; ir_l = 1'($urandom); ps = 2'($urandom);
            branch_off = 16'($urandom); jump_addr = 16'($urandom);
            imem_valid = 1'($urandom); imem_rdata = 16'($urandom);
            xq.push_back('{1'b0, model_pc, model_ir});
            @(posedge clk); #1;
            st = 1'b1;
            ns = ($urandom_range(0, 3) == 0);
        end else begin
            ns = 1'b0;
        end
        case ($urandom_range(0, 3))
            0:       bo = 16'h0003;
            1:       bo = 16'hFFFF;
            default: bo = 16'($urandom);
        endcase
        case ($urandom_range(0, 3))
            0:       ja = 16'hFFFE;
            1:       ja = 16'hFFFF;
            default: ja = 16'($urandom);
        endcase
        ir_l = !halt_now; ps = 2'($urandom); branch_off = bo; jump_addr = ja;
        imem_valid = 1'($urandom); imem_rdata = 16'($urandom);
        xq.push_back('{st, model_pc, model_ir});
        if (!halt_now) begin
            case (ps)
                2'd0:    model_pc = model_pc;
                2'd1:    model_pc = 16'((int'(model_pc) + 1) % 65536);
                2'd2:    model_pc = 16'((int'(model_pc) + 1 + int'(bo)) % 65536);
                default: model_pc = ja;
            endcase
        end
        @(posedge clk); #1;
        imem_valid = 1'b0; ns = 1'b0;
    endtask

    task automatic run_batch(input int n, input bit halt_last);
        for (int i = 0; i < n; i++) begin
            do_fetch();
            do_exec(halt_last && (i == n - 1));
        end
    endtask

    task automatic release_reset();
        @(posedge clk); #1;
        reset_n = 1'b1;
        @(posedge clk); #1;
        check("req_after_release", {31'h0, imem_req}, 32'd1);
        check("addr_after_release", {16'h0, imem_addr}, {16'h0, RESET_PC});
        model_pc = RESET_PC;
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check("rst_pc", {16'h0, pc}, {16'h0, RESET_PC});
        check("rst_ir", {16'h0, ir}, 32'd0);
        check("rst_state", {31'h0, state}, 32'd0);
        check("rst_req", {31'h0, imem_req}, 32'd0);
        check("rst_exec_en", {31'h0, exec_en}, 32'd0);
        check("rst_halted", {31'h0, halted}, 32'd0);
        check("rst_fault", {31'h0, fetch_fault}, 32'd0);
        release_reset();

`ifdef FETCH_TIMEOUT_EN
        begin
            int n;
            n = 0;
            imem_valid = 1'b0;
            while (imem_req && n < 500) begin
                @(posedge clk); #1;
                n++;
            end
            check("tmo_req_cycles", 32'(n), 32'(TMO));
            check("tmo_fault", {31'h0, fetch_fault}, 32'd1);
            check("tmo_halted", {31'h0, halted}, 32'd1);
            #2 reset_n = 1'b0;
            #1 check("tmo_fault_cleared", {31'h0, fetch_fault}, 32'd0);
            release_reset();
        end
`endif

        run_batch(150, 1'b1);
        for (int i = 0; i < 8; i++) begin
            imem_valid = 1'($urandom);
            @(posedge clk); #1;
            check("halt_halted", {31'h0, halted}, 32'd1);
            check("halt_req", {31'h0, imem_req}, 32'd0);
            check("halt_exec_en", {31'h0, exec_en}, 32'd0);
            check("halt_pc", {16'h0, pc}, {16'h0, model_pc});
        end
        imem_valid = 1'b0;

        #2 reset_n = 1'b0;
        #1;
        check("async_rst_halted", {31'h0, halted}, 32'd0);
        check("async_rst_pc", {16'h0, pc}, {16'h0, RESET_PC});
        release_reset();

        run_batch(40, 1'b0);
        imem_valid = 1'b0;
        @(posedge clk); #3;
        check("stall_req", {31'h0, imem_req}, 32'd1);
        reset_n = 1'b0;
        #1;
        check("midfetch_rst_req", {31'h0, imem_req}, 32'd0);
        check("fetch_q_empty", 32'(fq.size()), 32'd0);
        check("exec_q_empty", 32'(xq.size()), 32'd0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
